// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: key width and Montgomery multiplier states.
package rsa_pkg;

    // Default key width, shared by the constant generator, multiplier and exponentiation controller
    localparam int unsigned RSA_WIDTH = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } mont_state_t;

endpackage

// File: rtl/mont_cond_sub.sv
// Final Montgomery correction: returns s - n when s >= n, otherwise s.
// Kept as its own block so a pipelined version can replace it without touching the FSM.
module mont_cond_sub #(
    parameter int unsigned WIDTH = 1024
) (
    input  logic [WIDTH+1:0] i_s,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_res
);

    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Compare at full accumulator width; S < 2n means S - n always fits in WIDTH bits
    always_comb begin
        w_ge   = (i_s >= {2'b00, i_n});
        w_diff = i_s[WIDTH-1:0] - i_n;
        o_res  = w_ge ? w_diff : i_s[WIDTH-1:0];
    end

endmodule

// File: rtl/mont_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// One multiplier bit per cycle, then a single conditional subtraction.
module mont_mult_serial
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    mont_state_t        r_state;
    mont_state_t        w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH+1:0]   r_s;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH+1:0]   w_t_add;
    logic [WIDTH+1:0]   w_t_red;
    logic [WIDTH+1:0]   w_s_nxt;
    logic [WIDTH-1:0]   w_corr;

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: WIDTH loop iterations, one correction cycle, one done cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOOP;
            LOOP:    if (r_cnt == CNT_LAST) w_state_nxt = CORR;
            CORR:    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // One Montgomery iteration: S = (S + a_i*b [+ n]) / 2, with n added to make the sum even
    always_comb begin
        w_t_add = r_s + (r_a[0] ? {2'b00, r_b} : '0);
        w_t_red = w_t_add[0] ? (w_t_add + {2'b00, r_n}) : w_t_add;
        w_s_nxt = w_t_red >> 1;
    end

    mont_cond_sub #(
        .WIDTH (WIDTH)
    ) u_cond_sub (
        .i_s   (r_s),
        .i_n   (r_n),
        .o_res (w_corr)
    );

    // Operand latch, accumulator, counter and registered outputs.
    // The latched multiplier is shifted right each iteration so bit i is always at r_a[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_s      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_n    <= n;
                        r_s    <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                LOOP: begin
                    r_a   <= r_a >> 1;
                    r_s   <= w_s_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                CORR: begin
                    r_result <= w_corr;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
